// File: rtl/params_pkg.sv
// Shared widths, arbiter state encoding and the write-request record used by
// wb_stage, the long-latency unit and the register-file write arbiter.
package params_pkg;

    localparam int DATA_WIDTH           = 32;
    localparam int REG_ADDR_WIDTH       = 5;
    localparam int DEFAULT_STARVE_LIMIT = 4;

    typedef enum logic [0:0] {
        NORMAL  = 1'b0,
        FORCE_B = 1'b1
    } rf_arb_state_e;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     data;
    } rf_wr_req_t;

endpackage

// File: rtl/rf_wr_arbiter.sv
// Register-file write port arbiter: fixed priority to the writeback path (A),
// with a starvation guard that forces a long-latency (B) grant after a bounded wait.
//
// state   | meaning
// NORMAL  | A has priority; B waits and its stall cycles are counted
// FORCE_B | B has waited STARVE_LIMIT cycles; B is granted, A is held off
module rf_wr_arbiter #(
    parameter int DATA_WIDTH     = params_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = params_pkg::REG_ADDR_WIDTH,
    parameter int STARVE_LIMIT   = params_pkg::DEFAULT_STARVE_LIMIT
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      a_valid_i,
    output logic                      a_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0] a_rd_i,
    input  logic [DATA_WIDTH-1:0]     a_data_i,
    input  logic                      b_valid_i,
    output logic                      b_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0] b_rd_i,
    input  logic [DATA_WIDTH-1:0]     b_data_i,
    output logic                      rf_we_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0]     rf_wdata_o,
    output logic                      b_starved_o
`ifndef SYNTHESIS
    ,
    output logic [31:0]               debug_a_writes_o,
    output logic [31:0]               debug_b_writes_o
`endif
);

    import params_pkg::*;

    rf_arb_state_e state, state_d;
    logic [3:0]    starve_cnt, starve_cnt_d;
    logic          a_grant, b_grant;

    always_comb begin
        a_grant      = 1'b0;
        b_grant      = 1'b0;
        state_d      = state;
        starve_cnt_d = starve_cnt;
        if (rst_ni) begin
            case (state)
                NORMAL: begin
                    if (a_valid_i) begin
                        a_grant = 1'b1;
                    end else if (b_valid_i) begin
                        b_grant = 1'b1;
                    end
                    if (!b_valid_i || b_grant) begin
                        starve_cnt_d = 4'd0;
                    end else if (starve_cnt == 4'(STARVE_LIMIT - 1)) begin
                        starve_cnt_d = 4'd0;
                        state_d      = FORCE_B;
                    end else begin
                        starve_cnt_d = starve_cnt + 4'd1;
                    end
                end
                FORCE_B: begin
                    // A withdrawn B is a protocol error; drop back without granting A.
                    b_grant      = b_valid_i;
                    starve_cnt_d = 4'd0;
                    state_d      = NORMAL;
                end
                default: begin
                    starve_cnt_d = 4'd0;
                    state_d      = NORMAL;
                end
            endcase
        end
    end

    assign a_ready_o   = a_grant;
    assign b_ready_o   = b_grant;
    assign b_starved_o = (state == FORCE_B);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= NORMAL;
            starve_cnt <= 4'd0;
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else begin
            state      <= state_d;
            starve_cnt <= starve_cnt_d;
            // x0 handshakes complete but never reach the register file.
            rf_we_o    <= (a_grant && (a_rd_i != '0)) || (b_grant && (b_rd_i != '0));
            if (a_grant) begin
                rf_waddr_o <= a_rd_i;
                rf_wdata_o <= a_data_i;
            end else if (b_grant) begin
                rf_waddr_o <= b_rd_i;
                rf_wdata_o <= b_data_i;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            debug_a_writes_o <= 32'd0;
            debug_b_writes_o <= 32'd0;
        end else begin
            if (a_grant) debug_a_writes_o <= debug_a_writes_o + 32'd1;
            if (b_grant) debug_b_writes_o <= debug_b_writes_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Randomized and directed bench for rf_wr_arbiter against a behavioural model
// of the grant rule, starvation bound and one-cycle registered write port.
module tb_rf_wr_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_rd = '0, b_rd = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, rf_we, b_starved;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, dbg_a, dbg_b;

    rf_wr_arbiter #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .a_valid_i(a_valid), .a_ready_o(a_ready), .a_rd_i(a_rd), .a_data_i(a_data),
        .b_valid_i(b_valid), .b_ready_o(b_ready), .b_rd_i(b_rd), .b_data_i(b_data),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .b_starved_o(b_starved),
        .debug_a_writes_o(dbg_a), .debug_b_writes_o(dbg_b)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;

    // model: consecutive cycles B waited, expected registered write, handshake counts
    int          stall = 0;
    int          m_acnt = 0, m_bcnt = 0;
    logic        m_we = 1'b0, m_chk_addr = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic cycle(input logic rst, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br, input logic [31:0] bd);
        logic force_b, ga, gb;
        @(posedge clk); #1;
        rst_ni = rst; a_valid = av; a_rd = ar; a_data = ad;
        b_valid = bv; b_rd = br; b_data = bd;
        @(negedge clk);
        check("rf_we", {31'd0, rf_we}, {31'd0, m_we});
        if (m_we || m_chk_addr) begin
            check("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_addr});
            check("rf_wdata", rf_wdata, m_data);
        end
        check("debug_a", dbg_a, m_acnt);
        check("debug_b", dbg_b, m_bcnt);
        force_b = (stall >= LIMIT);
        gb = rst && bv && (force_b || !av);
        ga = rst && av && !force_b;
        check("a_ready", {31'd0, a_ready}, {31'd0, ga});
        check("b_ready", {31'd0, b_ready}, {31'd0, gb});
        check("b_starved", {31'd0, b_starved}, {31'd0, force_b});
        check("one_ready", {31'd0, a_ready && b_ready}, 32'd0);
        check("ready_wo_valid", {31'd0, (a_ready && !av) || (b_ready && !bv)}, 32'd0);
        if (!rst) begin
            stall = 0; m_acnt = 0; m_bcnt = 0;
            m_we = 1'b0; m_addr = '0; m_data = '0; m_chk_addr = 1'b1;
        end else begin
            m_chk_addr = 1'b0;
            m_we = (ga && ar != 0) || (gb && br != 0);
            if (ga) begin m_addr = ar; m_data = ad; m_acnt++; end
            else if (gb) begin m_addr = br; m_data = bd; m_bcnt++; end
            stall = (bv && !gb && !force_b) ? stall + 1 : 0;
        end
    endtask

    task automatic idle(input logic rst);
        cycle(rst, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        logic [9:0]  pat_b, pat_s;
        logic [4:0]  pat_r;
        logic [31:0] a0, b0;
        int          nb;
        logic        pa, pb, rst;
        logic [4:0]  ra, rb;
        logic [31:0] da, db;

        // reset state
        idle(1'b0); idle(1'b0);
        idle(1'b1);
        check("rst_we", {31'd0, rf_we}, 32'd0);
        check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_starved", {31'd0, b_starved}, 32'd0);

        // A only, one-cycle latency
        cycle(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
        check("a_only_ready", {31'd0, a_ready}, 32'd1);
        idle(1'b1);
        check("a_only_we", {31'd0, rf_we}, 32'd1);
        check("a_only_addr", {27'd0, rf_waddr}, 32'd5);
        check("a_only_data", rf_wdata, 32'hDEAD_BEEF);
        idle(1'b1);
        check("a_only_we_off", {31'd0, rf_we}, 32'd0);

        // simultaneous single requests
        cycle(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
        check("simul_a_first", {30'd0, a_ready, b_ready}, 32'd2);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h22);
        check("simul_b_next", {30'd0, a_ready, b_ready}, 32'd1);
        check("simul_w1", {rf_we, 26'd0, rf_waddr}, {1'b1, 26'd0, 5'd3});
        check("simul_d1", rf_wdata, 32'h11);
        idle(1'b1);
        check("simul_w2", {rf_we, 26'd0, rf_waddr}, {1'b1, 26'd0, 5'd7});
        check("simul_d2", rf_wdata, 32'h22);

        // starvation: both valid for 10 cycles
        idle(1'b1);
        a0 = dbg_a; b0 = dbg_b; nb = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 5'd1, 32'h100 + i, 1'b1, 5'd2, 32'h200 + nb);
            pat_b[i] = b_ready; pat_s[i] = b_starved;
            if (b_ready) nb++;
        end
        idle(1'b1);
        check("starve_b_pattern", {22'd0, pat_b}, 32'b10_0001_0000);
        check("starve_flag_pattern", {22'd0, pat_s}, 32'b10_0001_0000);
        check("starve_a_count", dbg_a - a0, 32'd8);
        check("starve_b_count", dbg_b - b0, 32'd2);

        // x0 write from B after a fresh reset
        idle(1'b0);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        check("x0_ready", {31'd0, b_ready}, 32'd1);
        idle(1'b1);
        check("x0_we", {31'd0, rf_we}, 32'd0);
        check("x0_debug_b", dbg_b, 32'd1);

        // reset mid-stream after two stalls
        cycle(1'b1, 1'b1, 5'd4, 32'hA1, 1'b1, 5'd6, 32'hB1);
        cycle(1'b1, 1'b1, 5'd4, 32'hA2, 1'b1, 5'd6, 32'hB1);
        cycle(1'b0, 1'b1, 5'd4, 32'hA3, 1'b1, 5'd6, 32'hB1);
        check("midrst_ready", {30'd0, a_ready, b_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 5'd4, 32'hC0 + i, 1'b1, 5'd6, 32'hD0);
            pat_r[i] = b_ready;
            if (i == 0) check("midrst_no_we", {31'd0, rf_we}, 32'd0);
        end
        check("midrst_force_at5", {27'd0, pat_r}, 32'b1_0000);

        // randomized traffic
        pa = 1'b0; pb = 1'b0; ra = '0; rb = '0; da = '0; db = '0;
        for (int i = 0; i < 1000; i++) begin
            if (!pa && $urandom_range(0, 9) < 6) begin
                pa = 1'b1; ra = 5'($urandom_range(0, 31)); da = $urandom;
            end
            if (!pb && $urandom_range(0, 9) < 5) begin
                pb = 1'b1; rb = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)); db = $urandom;
            end
            rst = ($urandom_range(0, 199) != 0);
            cycle(rst, pa, ra, da, pb, rb, db);
            if (!rst || a_ready) pa = 1'b0;
            if (!rst || b_ready) pb = 1'b0;
        end
        idle(1'b1);
        idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
